mac_table_learn: RTL
====================

// Module: mac_table_learn
// PURPOSE
// - Writer/owner of the shared MAC table: accepts learn requests carrying an 8-bit key and
//   refreshes a matching entry or allocates the lowest free slot. Periodically ages out
//   entries that have not been refreshed since the previous sweep.
// - Exports the table contents and a valid mask to the lookup/reader side.
// - my_pkg::one_hot_to_binary turns the one-hot match/free vectors into the slot index.
// PARAMETERS
// - N_ENTRIES   default my_pkg::PARAM_2 (32)    table depth; must be a power of 2
// - IDX_W       default my_pkg::PARAM_1 (5)     slot index width, $clog2(N_ENTRIES)
// - AGE_PERIOD  default my_pkg::PARAM_4 (10000) clk cycles between aging sweeps; >= 2
// PORTS
// - clk          in   1          clock; all state updates on the rising edge
// - rst_n        in   1          asynchronous, active-low reset
// - req_valid    in   1          learn request valid
// - req_ready    out  1          learn request accepted when req_valid && req_ready
// - req_key      in   8          key to learn (my_pkg::my_type)
// - resp_valid   out  1          one-cycle response pulse; no backpressure
// - resp_idx     out  IDX_W      slot written/refreshed; 0 when status is LEARN_FULL
// - resp_status  out  2          my_pkg::learn_status_t: LEARN_NEW / LEARN_REFRESH / LEARN_FULL
// - clear        in   1          synchronous flush of the whole table
// - tbl_o        out  8xN        table contents (my_pkg::T_MAC_TABLE)
// - tbl_valid_o  out  N_ENTRIES  per-slot valid mask
// BEHAVIOUR
// - Reset values:
//   - all outputs 0 except req_ready = 1
//   - valid, hit, tbl and age_cnt all 0; FSM in IDLE
// - State machine:
//   - IDLE -> CMP on an accepted request; key registered
//   - IDLE -> SWEEP when sweep_pend is set
//   - CMP -> RESP always
//   - RESP -> IDLE and SWEEP -> IDLE unconditionally
// - req_ready = (state==IDLE) && !sweep_pend && !clear.
// - Request latency: accept edge at cycle N; resp_valid is high in cycle N+2 only.
//   Throughput is 1 request per 3 cycles.
// - In CMP:
//   - match[i] = valid[i] && tbl[i]==key
//   - free = ~valid; lowest set bit isolated as free & -free
// - At the CMP->RESP edge:
//   - any match: hit[idx] <= 1; status LEARN_REFRESH; idx = binary(match)
//   - else any free slot: tbl[idx] <= key; valid[idx] <= 1; hit[idx] <= 1; status LEARN_NEW
//   - else: no write; status LEARN_FULL; idx = 0
//   - A key can never occupy two slots, so match is at most one-hot.
// - Aging:
//   - age_cnt counts 0..AGE_PERIOD-1 continuously and wraps.
//   - On wrap, sweep_pend <= 1.
//   - SWEEP: valid <= valid & hit; hit <= 0; sweep_pend <= 0.
//   - A wrap while the FSM is busy leaves sweep_pend set; the sweep runs on the next IDLE cycle.
//   - A pending sweep beats a new request in IDLE.
// - clear (any state):
//   - valid, hit and sweep_pend <= 0; FSM -> IDLE; any in-flight request is aborted (no resp_valid).
//   - tbl data is left as-is.
//   - age_cnt keeps running.
// - tbl_o/tbl_valid_o are registered state and visible the cycle after each write edge.
// STRUCTURE
// - my_pkg additions:
//   - typedef enum logic [1:0] {LEARN_NEW, LEARN_REFRESH, LEARN_FULL} learn_status_t
//   - localparam AGE_W = $clog2(PARAM_4)
// - Reuse my_type, T_MAC_TABLE and one_hot_to_binary from my_pkg.
// - One sub-module: mac_age_timer. It holds the period counter and emits a one-cycle wrap pulse.
// - FSM, compare and allocate logic stay in this module.
// TESTING
// - Reset then learn 0x11: resp in cycle N+2, LEARN_NEW, idx 0; tbl_valid_o = 0x1.
// - Learn 0x11 again: LEARN_REFRESH, idx 0. Learn 0x22: LEARN_NEW, idx 1.
// - Fill all 32 slots with keys 0..31, then learn 0xAA: LEARN_FULL, idx 0, table unchanged.
// - Aging (AGE_PERIOD=16):
//   - learn 0x11 and 0x22; refresh only 0x22 between sweep 1 and sweep 2
//   - after sweep 2: valid = 0x2 and 0x11 is gone
//   - a new learn of 0x33 allocates idx 0
// - Sweep/request collision: req_valid held high when wrap lands in CMP.
//   - The response completes first.
//   - SWEEP runs before the next accept; req_ready stays low during SWEEP.
// - Assert clear in cycle N+1 of a request: no resp_valid, valid = 0, req_ready high on the next cycle.

Source files
------------

// File: rtl/my_pkg.sv
// Shared MAC-table types, default sizes and the one-hot to binary encoder
// used by the learn side and the lookup side.
package my_pkg;

    localparam int PARAM_1 = 5;
    localparam int PARAM_2 = 32;
    localparam int PARAM_4 = 10000;
    localparam int AGE_W   = $clog2(PARAM_4);

    typedef logic [7:0] my_type;
    typedef my_type [PARAM_2-1:0] T_MAC_TABLE;

    typedef enum logic [1:0] {LEARN_NEW, LEARN_REFRESH, LEARN_FULL} learn_status_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_RESP, ST_SWEEP} learn_state_t;

    // ORing the indices of all set bits gives the position when at most one bit is set.
    function automatic logic [PARAM_1-1:0] one_hot_to_binary(input logic [PARAM_2-1:0] oh);
        logic [PARAM_1-1:0] bin;
        bin = '0;
        for (int i = 0; i < PARAM_2; i++) begin
            if (oh[i]) begin
                bin = bin | PARAM_1'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/mac_age_timer.sv
// Free-running aging period counter; o_wrap is high for the one cycle in
// which the counter sits at PERIOD-1 and is about to return to zero.
module mac_age_timer
    import my_pkg::*;
#(
    parameter int PERIOD = PARAM_4,
    parameter int CNT_W  = AGE_W
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end = (r_cnt == CNT_W'(PERIOD - 1));
    assign o_wrap   = w_at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_at_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mac_table_learn.sv
// Owner of the shared MAC table: learns/refreshes keys, allocates the lowest
// free slot, and periodically ages out entries not refreshed since the last sweep.
module mac_table_learn
    import my_pkg::*;
#(
    parameter int N_ENTRIES  = PARAM_2,
    parameter int IDX_W      = PARAM_1,
    parameter int AGE_PERIOD = PARAM_4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  my_type                  req_key,
    output logic                    resp_valid,
    output logic [IDX_W-1:0]        resp_idx,
    output learn_status_t           resp_status,
    input  logic                    clear,
    output my_type [N_ENTRIES-1:0]  tbl_o,
    output logic [N_ENTRIES-1:0]    tbl_valid_o
);

    localparam int AGE_CW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    learn_state_t           r_state;
    learn_state_t           w_next_state;
    my_type                 r_key;
    my_type [N_ENTRIES-1:0] r_tbl;
    logic [N_ENTRIES-1:0]   r_valid;
    logic [N_ENTRIES-1:0]   r_hit;
    logic                   r_sweep_pend;
    logic [IDX_W-1:0]       r_resp_idx;
    learn_status_t          r_resp_status;

    logic [N_ENTRIES-1:0]   w_match;
    logic [N_ENTRIES-1:0]   w_free;
    logic [N_ENTRIES-1:0]   w_free_low;
    logic                   w_any_match;
    logic                   w_any_free;
    logic                   w_accept;
    logic                   w_wrap;
    logic [IDX_W-1:0]       w_match_idx;
    logic [IDX_W-1:0]       w_free_idx;

    mac_age_timer #(
        .PERIOD (AGE_PERIOD),
        .CNT_W  (AGE_CW)
    ) u_age_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_wrap (w_wrap)
    );

    assign req_ready   = (r_state == ST_IDLE) && !r_sweep_pend && !clear;
    assign w_accept    = req_valid && req_ready;
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_idx    = r_resp_idx;
    assign resp_status = r_resp_status;
    assign tbl_o       = r_tbl;
    assign tbl_valid_o = r_valid;

    // A key is only ever written into a free slot after a miss, so w_match stays one-hot.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_match[i] = r_valid[i] && (r_tbl[i] == r_key);
        end
    end

    assign w_free      = ~r_valid;
    assign w_free_low  = w_free & (-w_free);
    assign w_any_match = |w_match;
    assign w_any_free  = |w_free;
    assign w_match_idx = IDX_W'(one_hot_to_binary(PARAM_2'(w_match)));
    assign w_free_idx  = IDX_W'(one_hot_to_binary(PARAM_2'(w_free_low)));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_sweep_pend) begin
                    w_next_state = ST_SWEEP;
                end else if (w_accept) begin
                    w_next_state = ST_CMP;
                end
            end
            ST_CMP:   w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            ST_SWEEP: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (clear) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // clear aborts an in-flight compare, so no table or response update happens under it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key         <= '0;
            r_tbl         <= '0;
            r_valid       <= '0;
            r_hit         <= '0;
            r_sweep_pend  <= 1'b0;
            r_resp_idx    <= '0;
            r_resp_status <= LEARN_NEW;
        end else begin
            if (w_accept) begin
                r_key <= req_key;
            end
            if (clear) begin
                r_valid      <= '0;
                r_hit        <= '0;
                r_sweep_pend <= 1'b0;
            end else begin
                if (w_wrap) begin
                    r_sweep_pend <= 1'b1;
                end else if (r_state == ST_SWEEP) begin
                    r_sweep_pend <= 1'b0;
                end
                if (r_state == ST_SWEEP) begin
                    r_valid <= r_valid & r_hit;
                    r_hit   <= '0;
                end else if (r_state == ST_CMP) begin
                    if (w_any_match) begin
                        r_hit[w_match_idx] <= 1'b1;
                        r_resp_idx         <= w_match_idx;
                        r_resp_status      <= LEARN_REFRESH;
                    end else if (w_any_free) begin
                        r_tbl[w_free_idx]   <= r_key;
                        r_valid[w_free_idx] <= 1'b1;
                        r_hit[w_free_idx]   <= 1'b1;
                        r_resp_idx          <= w_free_idx;
                        r_resp_status       <= LEARN_NEW;
                    end else begin
                        r_resp_idx    <= '0;
                        r_resp_status <= LEARN_FULL;
                    end
                end
            end
        end
    end

endmodule
